// File: rtl/iq_player_pkg.sv
// Shared register map, bit positions and DAC midscale for the I/Q sample player.
package iq_player_pkg;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_DIV    = 2'd1,
    ADDR_DATA   = 2'd2,
    ADDR_STATUS = 2'd3
  } reg_addr_e;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_UNDERFLOW = 2;
  localparam int STAT_OVERFLOW  = 3;

  localparam logic [9:0] MIDSCALE = 10'h200;

  // Offset-binary zero for a DAC of arbitrary width.
  function automatic logic [31:0] midscale_for(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with flush; head is valid whenever
// empty is low.
module sync_fifo_fwft #(
  parameter int width      = 20,
  parameter int depth_log2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetb,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [width-1:0]      i_data,
  output logic [width-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [depth_log2:0]   o_level
);

  localparam int L_LVL_W = depth_log2 + 1;
  localparam logic [depth_log2:0] L_DEPTH = {1'b1, {depth_log2{1'b0}}};

  logic [width-1:0]      r_mem [2**depth_log2];
  logic [depth_log2-1:0] r_wr_ptr;
  logic [depth_log2-1:0] r_rd_ptr;
  logic [depth_log2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == L_DEPTH);
  assign o_level = r_level;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  // Asynchronous read so the head falls through without an extra cycle.
  assign o_head = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + depth_log2'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + depth_log2'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + L_LVL_W'(1);
        2'b01:   r_level <= r_level - L_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/iq_sample_player_wb.sv
// Wishbone slave that queues host I/Q pairs and replays them to the DAC buses
// at a programmable sample period.
module iq_sample_player_wb
  import iq_player_pkg::*;
#(
  parameter int output_dac_width = 10,
  parameter int fifo_depth_log2  = 8,
  parameter int divider_width    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_resetb,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [1:0]                  i_wb_addr,
  input  logic [31:0]                 i_wb_data,
  output logic                        o_wb_ack,
  output logic                        o_wb_stall,
  output logic [31:0]                 o_wb_data,
  output logic [output_dac_width-1:0] o_dac_a,
  output logic [output_dac_width-1:0] o_dac_b,
  output logic                        o_sample_stb,
  output logic                        o_underflow
);

  localparam int L_W      = output_dac_width;
  localparam int L_PAIR_W = 2 * output_dac_width;
  localparam logic [L_W-1:0] L_MID = L_W'(midscale_for(output_dac_width));

  logic                       r_ack;
  logic [31:0]                r_wb_data;
  logic                       r_enable;
  logic [divider_width-1:0]   r_div;
  logic [divider_width-1:0]   r_cnt;
  logic [L_W-1:0]             r_dac_a;
  logic [L_W-1:0]             r_dac_b;
  logic                       r_sample_stb;
  logic                       r_underflow;
  logic                       r_overflow;

  reg_addr_e                  w_addr;
  logic                       w_acc;
  logic                       w_wr;
  logic                       w_ctrl_wr;
  logic                       w_div_wr;
  logic                       w_stat_wr;
  logic                       w_push;
  logic                       w_flush;
  logic                       w_disable;
  logic                       w_tick;
  logic                       w_pop;
  logic                       w_push_drop;
  logic [L_PAIR_W-1:0]        w_push_data;
  logic [L_PAIR_W-1:0]        w_head;
  logic                       w_empty;
  logic                       w_full;
  logic [fifo_depth_log2:0]   w_level;
  logic [31:0]                w_rd_data;
  logic                       w_unused_data;

  assign w_addr    = reg_addr_e'(i_wb_addr);
  assign w_acc     = i_wb_cyc & i_wb_stb;
  assign w_wr      = w_acc & i_wb_we;
  assign w_ctrl_wr = w_wr & (w_addr == ADDR_CTRL);
  assign w_div_wr  = w_wr & (w_addr == ADDR_DIV);
  assign w_stat_wr = w_wr & (w_addr == ADDR_STATUS);
  assign w_push    = w_wr & (w_addr == ADDR_DATA);
  assign w_flush   = w_ctrl_wr & i_wb_data[CTRL_FLUSH];
  assign w_disable = w_ctrl_wr & ~i_wb_data[CTRL_ENABLE];

  // A disable landing on a terminal count wins: no sample is consumed.
  assign w_tick      = r_enable & (r_cnt == r_div) & ~w_disable;
  assign w_pop       = w_tick & ~w_empty & ~w_flush;
  assign w_push_drop = w_push & w_full & ~w_pop & ~w_flush;
  assign w_push_data = {i_wb_data[16 +: L_W], i_wb_data[0 +: L_W]};

  assign w_unused_data = &{1'b0, i_wb_data[31:16+L_W]};

  sync_fifo_fwft #(
    .width      (L_PAIR_W),
    .depth_log2 (fifo_depth_log2)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_resetb (i_resetb),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .i_data   (w_push_data),
    .o_head   (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_level  (w_level)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_addr)
      ADDR_CTRL:   w_rd_data[CTRL_ENABLE] = r_enable;
      ADDR_DIV:    w_rd_data[divider_width-1:0] = r_div;
      ADDR_DATA:   w_rd_data[fifo_depth_log2:0] = w_level;
      ADDR_STATUS: begin
        w_rd_data[STAT_EMPTY]     = w_empty;
        w_rd_data[STAT_FULL]      = w_full;
        w_rd_data[STAT_UNDERFLOW] = r_underflow;
        w_rd_data[STAT_OVERFLOW]  = r_overflow;
      end
      default:     w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_ack        <= 1'b0;
      r_wb_data    <= '0;
      r_enable     <= 1'b0;
      r_div        <= '0;
      r_cnt        <= '0;
      r_dac_a      <= L_MID;
      r_dac_b      <= L_MID;
      r_sample_stb <= 1'b0;
      r_underflow  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) begin
        r_wb_data <= i_wb_we ? 32'd0 : w_rd_data;
      end

      if (w_ctrl_wr) r_enable <= i_wb_data[CTRL_ENABLE];
      if (w_div_wr)  r_div    <= i_wb_data[divider_width-1:0];

      if (w_div_wr || !r_enable || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + divider_width'(1);
      end

      r_sample_stb <= 1'b0;
      if (w_disable) begin
        r_dac_a <= L_MID;
        r_dac_b <= L_MID;
      end else if (w_tick) begin
        if (w_pop) begin
          r_dac_a      <= w_head[L_PAIR_W-1 -: L_W];
          r_dac_b      <= w_head[L_W-1:0];
          r_sample_stb <= 1'b1;
        end else begin
          r_dac_a <= L_MID;
          r_dac_b <= L_MID;
        end
      end

      // Hardware set beats a simultaneous host clear so no event is lost.
      if (w_stat_wr && i_wb_data[STAT_UNDERFLOW]) r_underflow <= 1'b0;
      if (w_tick && !w_pop)                       r_underflow <= 1'b1;
      if (w_stat_wr && i_wb_data[STAT_OVERFLOW])  r_overflow  <= 1'b0;
      if (w_push_drop)                            r_overflow  <= 1'b1;
    end
  end

  assign o_wb_ack     = r_ack;
  assign o_wb_stall   = 1'b0;
  assign o_wb_data    = r_wb_data;
  assign o_dac_a      = r_dac_a;
  assign o_dac_b      = r_dac_b;
  assign o_sample_stb = r_sample_stb;
  assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_iq_sample_player_wb.sv
// Directed bench for iq_sample_player_wb: a queue-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_iq_sample_player_wb;

  localparam logic [9:0] MID = 10'h200;

  logic        i_clk = 1'b0;
  logic        i_resetb = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = 2'd0;
  logic [31:0] i_wb_data = 32'd0;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic [9:0]  o_dac_a;
  logic [9:0]  o_dac_b;
  logic        o_sample_stb;
  logic        o_underflow;

  iq_sample_player_wb dut (
    .i_clk        (i_clk),
    .i_resetb     (i_resetb),
    .i_wb_cyc     (i_wb_cyc),
    .i_wb_stb     (i_wb_stb),
    .i_wb_we      (i_wb_we),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .o_wb_ack     (o_wb_ack),
    .o_wb_stall   (o_wb_stall),
    .o_wb_data    (o_wb_data),
    .o_dac_a      (o_dac_a),
    .o_dac_b      (o_dac_b),
    .o_sample_stb (o_sample_stb),
    .o_underflow  (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [19:0] m_q[$];
  bit          m_en = 0;
  int          m_div = 0;
  int          m_since = 0;
  bit          m_unf = 0;
  bit          m_ovf = 0;
  bit          e_ack = 0;
  bit          e_stb = 0;
  logic [31:0] e_rdata = 32'd0;
  logic [9:0]  e_a = MID;
  logic [9:0]  e_b = MID;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_en};
      2'd1:    return 32'(m_div);
      2'd2:    return 32'(m_q.size());
      default: return {28'd0, m_ovf, m_unf, 1'b0 | (m_q.size() == 256), 1'b0 | (m_q.size() == 0)};
    endcase
  endfunction

  always @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      m_q.delete();
      m_en = 0; m_div = 0; m_since = 0; m_unf = 0; m_ovf = 0;
      e_ack = 0; e_stb = 0; e_rdata = 32'd0; e_a = MID; e_b = MID;
    end else begin
      bit acc, wr, ctrl_wr, flush, dis, tick;
      logic [1:0]  a;
      logic [31:0] d;
      logic [19:0] p;
      acc = i_wb_cyc && i_wb_stb;
      wr  = acc && i_wb_we;
      a   = i_wb_addr;
      d   = i_wb_data;
      e_ack = acc;
      if (acc) e_rdata = wr ? 32'd0 : model_read(a);
      ctrl_wr = wr && (a == 2'd0);
      flush   = ctrl_wr && d[1];
      dis     = ctrl_wr && !d[0];
      // a tick falls every (div+1)th enabled cycle
      tick    = m_en && !dis && ((m_since % (m_div + 1)) == m_div);
      e_stb = 0;
      if (wr && a == 2'd3) begin
        if (d[2]) m_unf = 0;
        if (d[3]) m_ovf = 0;
      end
      if (tick) begin
        if (m_q.size() > 0 && !flush) begin
          p = m_q.pop_front();
          e_a = p[19:10]; e_b = p[9:0]; e_stb = 1;
        end else begin
          e_a = MID; e_b = MID; m_unf = 1;
        end
      end
      if (dis) begin e_a = MID; e_b = MID; end
      if (flush) m_q.delete();
      else if (wr && a == 2'd2) begin
        if (m_q.size() < 256) m_q.push_back({d[25:16], d[9:0]});
        else m_ovf = 1;
      end
      if (m_en) m_since++;
      if (ctrl_wr) m_en = d[0];
      if (!m_en) m_since = 0;
      if (wr && a == 2'd1) begin m_div = int'(d[15:0]); m_since = 0; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    check("ack", 32'(o_wb_ack), 32'(e_ack));
    check("stall", 32'(o_wb_stall), 32'd0);
    check("dac_a", 32'(o_dac_a), 32'(e_a));
    check("dac_b", 32'(o_dac_b), 32'(e_b));
    check("sample_stb", 32'(o_sample_stb), 32'(e_stb));
    check("underflow", 32'(o_underflow), 32'(m_unf));
    if (e_ack || !i_resetb) check("rdata", o_wb_data, e_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic bus_go(input bit we, input logic [1:0] a, input logic [31:0] d);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
    @(posedge i_clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    bus_go(1, a, d);
    $display("WR addr=%0d data=%08h", a, d);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    bus_go(0, a, 32'd0);
    d = o_wb_data;
    $display("RD addr=%0d data=%08h", a, d);
  endtask

  task automatic edges(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  function automatic logic [31:0] fill(input int i);
    return {6'd0, 10'(i + 1), 6'd0, 10'(1023 - i)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    edges(2);
    check("rst_dac_a", 32'(o_dac_a), 32'h200);
    check("rst_ack", 32'(o_wb_ack), 32'd0);
    check("rst_rdata", o_wb_data, 32'd0);
    i_resetb = 1;

    // Two samples at DIV=3, then underflow.
    wb_write(2'd1, 32'd3);
    wb_write(2'd2, 32'h0123_0045);
    wb_write(2'd2, 32'h00AA_0155);
    wb_write(2'd0, 32'd1);
    edges(3);
    check("pre_tick_dac_a", 32'(o_dac_a), 32'h200);
    edges(1);
    check("tick1_dac_a", 32'(o_dac_a), 32'h123);
    check("tick1_dac_b", 32'(o_dac_b), 32'h045);
    check("tick1_stb", 32'(o_sample_stb), 32'd1);
    edges(4);
    check("tick2_dac_a", 32'(o_dac_a), 32'h0AA);
    check("tick2_dac_b", 32'(o_dac_b), 32'h155);
    edges(4);
    check("tick3_dac_a", 32'(o_dac_a), 32'h200);
    wb_read(2'd3, rd);
    check("status_underflow", rd, 32'h5);
    wb_write(2'd0, 32'd0);
    wb_write(2'd3, 32'h4);
    wb_read(2'd3, rd);
    check("status_w1c", rd, 32'h1);
    check("underflow_cleared", 32'(o_underflow), 32'd0);

    // Overflow with 257 pushes, then flush.
    for (int i = 0; i < 257; i++) wb_write(2'd2, fill(i));
    wb_read(2'd2, rd);
    check("level_full", rd, 32'd256);
    wb_read(2'd3, rd);
    check("status_full_ovf", rd, 32'hA);
    wb_write(2'd0, 32'd2);
    wb_read(2'd2, rd);
    check("level_flushed", rd, 32'd0);
    wb_read(2'd3, rd);
    check("status_after_flush", rd, 32'h9);
    wb_write(2'd3, 32'h8);

    // Full FIFO, DIV=0, push every cycle.
    for (int i = 0; i < 256; i++) wb_write(2'd2, fill(i));
    wb_write(2'd1, 32'd0);
    wb_write(2'd0, 32'd1);
    for (int i = 0; i < 20; i++) begin
      wb_write(2'd2, 32'h0300_0011 + 32'(i));
      check("stream_stb", 32'(o_sample_stb), 32'd1);
      if (i == 0) begin
        check("stream_first_a", 32'(o_dac_a), 32'h001);
        check("stream_first_b", 32'(o_dac_b), 32'h3FF);
      end
    end
    wb_read(2'd2, rd);
    check("stream_level", rd, 32'd256);
    wb_read(2'd3, rd);
    check("stream_status", rd, 32'h0);
    wb_write(2'd0, 32'd2);

    // Four back-to-back strobes.
    wb_write(2'd2, 32'h03C1_00F0);
    check("b2b_ack1", 32'(o_wb_ack), 32'd1);
    wb_read(2'd2, rd);
    check("b2b_level1", rd, 32'd1);
    wb_write(2'd2, 32'h0055_0066);
    check("b2b_ack3", 32'(o_wb_ack), 32'd1);
    wb_read(2'd2, rd);
    check("b2b_level2", rd, 32'd2);
    edges(1);
    check("b2b_ack_end", 32'(o_wb_ack), 32'd0);

    // Asynchronous reset mid-stream.
    wb_write(2'd1, 32'd1);
    wb_write(2'd0, 32'd1);
    edges(3);
    check("pre_reset_dac_a", 32'(o_dac_a), 32'h3C1);
    #3 i_resetb = 0;
    #1;
    check("async_rst_dac_a", 32'(o_dac_a), 32'h200);
    check("async_rst_dac_b", 32'(o_dac_b), 32'h200);
    check("async_rst_stb", 32'(o_sample_stb), 32'd0);
    edges(2);
    i_resetb = 1;
    wb_read(2'd3, rd);
    check("post_reset_status", rd, 32'h1);
    wb_read(2'd0, rd);
    check("post_reset_ctrl", rd, 32'h0);
    wb_read(2'd1, rd);
    check("post_reset_div", rd, 32'h0);
    edges(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iq_sample_player_wb.md
Name: iq_sample_player_wb

Overview:
- Wishbone slave that buffers host-written I/Q sample pairs in a FIFO.
- Plays the pairs out to the two 10-bit DAC buses at a programmable sample rate.
- Sits on the hbbus wishbone fabric as a peer of the FM generator slave, in its own address page.
- It is an alternative driver of the same o_dac_a/o_dac_b pins, for arbitrary baseband waveforms; top-level muxing is handled elsewhere.

Parameters:
- output_dac_width, 10: DAC sample width.
- fifo_depth_log2, 8: FIFO holds 2**fifo_depth_log2 sample pairs.
- divider_width, 16: width of the sample-period divider.

Ports:
- i_clk  in  1  system clock.
- i_resetb  in  1  asynchronous active-low reset.
- i_wb_cyc  in  1  wishbone cycle.
- i_wb_stb  in  1  strobe, already qualified by page select.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  2  register word address.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  stall, tied 0.
- o_wb_data  out  32  read data.
- o_dac_a  out  output_dac_width  I sample, offset binary.
- o_dac_b  out  output_dac_width  Q sample, offset binary.
- o_sample_stb  out  1  one-cycle pulse when o_dac_a/b take a new FIFO sample.
- o_underflow  out  1  sticky underflow flag, mirrors STATUS[2].

Behaviour:
- Reset values (asynchronous, i_resetb=0):
  - o_wb_ack=0, o_wb_data=0, o_sample_stb=0.
  - o_dac_a=o_dac_b=MIDSCALE (10'h200).
  - CTRL=0, DIV=0, FIFO empty, sticky flags 0, divider counter 0.
- Bus handshake:
  - Every cycle with i_wb_stb=1 is accepted; o_wb_stall is constant 0.
  - o_wb_ack=1 exactly one cycle after each accepted strobe.
  - o_wb_data is valid in that same ack cycle.
  - Back-to-back strobes give back-to-back acks.
- Register map (word address):
  - 0 CTRL (RW): bit0 enable, bit1 flush (self-clearing; reads 0; empties FIFO in the cycle after the write).
  - 1 DIV (RW, [divider_width-1:0]): sample period is DIV+1 clocks.
  - 2 DATA: write pushes {I=data[25:16], Q=data[9:0]}; read returns FIFO level, zero-extended.
  - 3 STATUS: bit0 empty, bit1 full, bit2 underflow (sticky), bit3 overflow (sticky). Write-1-to-clear on bits 2 and 3; bits 0 and 1 are read-only.
- Divider:
  - Runs only while enabled. Counts 0..DIV, and the terminal count produces a tick; then it wraps to 0.
  - DIV=0 gives a tick every cycle.
  - Writing DIV resets the counter to 0.
  - While disabled, the counter is held at 0, so the first tick comes DIV+1 cycles after enable.
- Tick with FIFO non-empty:
  - Pop the head (first-word-fall-through).
  - o_dac_a/b take the head value on the next edge, with o_sample_stb=1 in that same cycle.
- Tick with FIFO empty:
  - o_dac_a/b take MIDSCALE, set underflow, o_sample_stb=0.
- Disable (enable written 0):
  - o_dac_a/b go to MIDSCALE on the next edge.
  - FIFO contents are retained.
- Push/pop boundary cases:
  - Push while full and no pop in the same cycle: data dropped, overflow set.
  - Push and pop in the same cycle while full: both occur; level is unchanged, overflow not set.
  - Push and tick in the same cycle while empty: underflow is set, and the pushed word stays for the next tick.
  - Flush and push in the same cycle: flush wins and the word is discarded.
  - Flush does not clear the sticky flags.
- Reset asserted mid-operation: everything returns to the reset values immediately, without waiting for a clock edge.
- Widths:
  - FIFO level is fifo_depth_log2+1 bits, range 0..2**fifo_depth_log2.
  - Pointers wrap modulo the depth.

Decomposition:
- Package iq_player_pkg holds:
  - register address constants ADDR_CTRL=0, ADDR_DIV=1, ADDR_DATA=2, ADDR_STATUS=3;
  - STATUS bit indices;
  - MIDSCALE.
- Sub-module sync_fifo_fwft:
  - parameters width and depth_log2;
  - push, pop and flush inputs;
  - head, empty, full and level outputs;
  - same clock and async active-low reset.

Test Plan:
- Reset with i_resetb=0 mid-stream → outputs 10'h200 immediately; read STATUS → 0x1.
- Write DIV=3, push 0x01230045 and 0x00AA0155, set CTRL=1 →
  - o_dac_a=0x123/o_dac_b=0x045 with o_sample_stb on the first tick;
  - 0x0AA/0x155 four clocks later;
  - then 0x200 with STATUS reading 0x5 (empty + underflow).
- Write 1 to STATUS bit2 → STATUS reads 0x1; o_underflow=0.
- Push 257 words with enable=0 (depth 256) → level=256, STATUS=0xA (full + overflow); CTRL=2 (flush) → level=0, STATUS=0x9 (empty + overflow).
- Fill the FIFO, enable with DIV=0, push on every cycle → no overflow, level stays at 256, o_sample_stb high every cycle.
- Issue strobes on 4 consecutive cycles, mixing reads and writes → 4 consecutive acks each one cycle late; a DATA read returns the correct level each time.
